// File: rtl/issue_dispatch_queue_if.sv
// Control-word type shared by the issue stage and the handshake bundle between the
// instruction register, the issue/dispatch queue and the ROB/reservation stations.
package tomasula_types;
  typedef enum logic [3:0] {
    ADD    = 4'd0,
    SUB    = 4'd1,
    MUL    = 4'd2,
    SHL    = 4'd3,
    SHR    = 4'd4,
    CMP    = 4'd5,
    BRANCH = 4'd6,
    LD     = 4'd7,
    ST     = 4'd8
  } op_t;

  typedef struct packed {
    op_t         op;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [15:0] imm;
  } ctl_word;
endpackage

interface issue_dispatch_queue_if #(
  parameter int DEPTH = 8,
  parameter int N_RS  = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic                    flush;
  logic                    ld_iq;
  tomasula_types::ctl_word control_word_i;
  logic                    ack_o;
  logic                    issue_q_full_n;
  logic [N_RS-1:0]         rs_empty;
  logic                    resbr_empty;
  logic                    rob_full;
  logic                    ldst_q_full;
  logic                    rob_load;
  logic [N_RS-1:0]         rs_load;
  logic                    resbr_load;
  logic                    ldst_load;
  tomasula_types::ctl_word control_o;
  logic [CW-1:0]           count_o;

  modport master (
    output flush, ld_iq, control_word_i, rs_empty, resbr_empty, rob_full, ldst_q_full,
    input  ack_o, issue_q_full_n, rob_load, rs_load, resbr_load, ldst_load, control_o, count_o
  );

  modport slave (
    input  flush, ld_iq, control_word_i, rs_empty, resbr_empty, rob_full, ldst_q_full,
    output ack_o, issue_q_full_n, rob_load, rs_load, resbr_load, ldst_load, control_o, count_o
  );
endinterface

// File: rtl/issue_dispatch_queue.sv
// Issue/dispatch queue: circular buffer of control words routed to ALU, branch or load/store
// stations. Define IQ_RR_ARB_EN for round-robin ALU station arbitration (default: lowest index).
module issue_dispatch_queue
  import tomasula_types::*;
#(
  parameter int DEPTH = 8,
  parameter int N_RS  = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  issue_dispatch_queue_if.slave iq
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int RW = (N_RS > 1) ? $clog2(N_RS) : 1;

  typedef enum logic [1:0] {TGT_ALU, TGT_BR, TGT_LDST} target_e;

  ctl_word         mem_q [DEPTH];
  logic [PW-1:0]   head_q, head_d;
  logic [PW-1:0]   tail_q, tail_d;
  logic [CW-1:0]   count_q, count_d;
  logic            full_n;
  logic            has_entry;
  logic            enq;
  logic            dispatch;
  logic            tgt_avail;
  target_e         tgt;
  ctl_word         head_word;
  logic [RW-1:0]   grant_idx;
  logic [RW-1:0]   cand;
  logic [N_RS-1:0] grant_oh;

  assign full_n    = (count_q != CW'(DEPTH));
  assign has_entry = (count_q != '0);
  assign head_word = mem_q[head_q];
  assign enq       = iq.ld_iq & full_n & ~iq.flush;

  // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    tgt       = TGT_ALU;
    tgt_avail = |iq.rs_empty;
    case (head_word.op)
      BRANCH: begin
        tgt       = TGT_BR;
        tgt_avail = iq.resbr_empty;
      end
      LD, ST: begin
        tgt       = TGT_LDST;
        tgt_avail = ~iq.ldst_q_full;
      end
      default: ;
    endcase
  end

  assign dispatch = has_entry & ~iq.rob_full & ~iq.flush & tgt_avail;

`ifdef IQ_RR_ARB_EN
  logic [RW-1:0] rr_q, rr_d;
  logic          found;

  // First free station at or after rr_q, searching cyclically.
  always_comb begin
    grant_idx = '0;
    cand      = '0;
    found     = 1'b0;
    for (int k = 0; k < N_RS; k++) begin
      cand = RW'((int'(rr_q) + k) % N_RS);
      if (!found && iq.rs_empty[cand]) begin
        grant_idx = cand;
        found     = 1'b1;
      end
    end
    rr_d = (grant_idx == RW'(N_RS - 1)) ? '0 : grant_idx + RW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_q <= '0;
    end else if (dispatch && tgt == TGT_ALU) begin
      rr_q <= rr_d;
    end
  end
`else
  // Descending scan so the lowest set bit is the last (winning) assignment.
  always_comb begin
    grant_idx = '0;
    cand      = '0;
    for (int k = N_RS - 1; k >= 0; k--) begin
      cand = RW'(k);
      if (iq.rs_empty[cand]) grant_idx = cand;
    end
  end
`endif

  always_comb begin
    grant_oh            = '0;
    grant_oh[grant_idx] = 1'b1;
  end

  assign iq.rob_load       = dispatch;
  assign iq.rs_load        = (dispatch && tgt == TGT_ALU) ? grant_oh : '0;
  assign iq.resbr_load     = dispatch & (tgt == TGT_BR);
  assign iq.ldst_load      = dispatch & (tgt == TGT_LDST);
  assign iq.control_o      = has_entry ? head_word : '0;
  assign iq.count_o        = count_q;
  assign iq.issue_q_full_n = full_n;
  // Registered state already reads as empty in reset; only the combinational ack needs gating.
  assign iq.ack_o          = enq & rst_n;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (iq.flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (dispatch) head_d = head_q + PW'(1);
      if (enq)      tail_d = tail_q + PW'(1);
      case ({enq, dispatch})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: ;
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // NOTE: entry storage is deliberately not reset; count_q alone decides which entries are valid.
  always_ff @(posedge clk) begin
    if (enq) mem_q[tail_q] <= iq.control_word_i;
  end
endmodule

// File: tb/tb_issue_dispatch_queue.sv
// Self-checking bench for issue_dispatch_queue: directed scenarios plus randomized traffic,
// all compared against a queue-based reference model.
module tb_issue_dispatch_queue;
  import tomasula_types::*;

  localparam int DEPTH = 8;
  localparam int N_RS  = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  issue_dispatch_queue_if #(.DEPTH(DEPTH), .N_RS(N_RS)) iq ();

  issue_dispatch_queue #(.DEPTH(DEPTH), .N_RS(N_RS)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .iq    (iq)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: the queue contents in order, plus the round-robin pointer.
  ctl_word mq[$];
  int      rr = 0;

  logic            obs_ack, obs_full_n, obs_rob, obs_br, obs_ls;
  logic [N_RS-1:0] obs_rs;
  logic [63:0]     obs_count;
  ctl_word         obs_ctl;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic ctl_word mk(input op_t op);
    ctl_word w;
    w.op  = op;
    w.rd  = 5'($urandom);
    w.rs1 = 5'($urandom);
    w.rs2 = 5'($urandom);
    w.imm = 16'($urandom);
    return w;
  endfunction

  function automatic ctl_word mk_rand();
    return mk(op_t'($urandom_range(0, 8)));
  endfunction

  // 0 = ALU, 1 = branch, 2 = load/store
  function automatic int target_of(input op_t op);
    if (op == BRANCH) return 1;
    if (op == LD || op == ST) return 2;
    return 0;
  endfunction

  function automatic int pick(input logic [N_RS-1:0] rse);
`ifdef IQ_RR_ARB_EN
    for (int k = 0; k < N_RS; k++)
      if (rse[(rr + k) % N_RS]) return (rr + k) % N_RS;
`else
    for (int k = 0; k < N_RS; k++)
      if (rse[k]) return k;
`endif
    return -1;
  endfunction

  // One clock cycle: drive, predict, sample at negedge, compare, then advance the model.
  task automatic step(input logic ld, input ctl_word w, input logic fl,
                      input logic [N_RS-1:0] rse, input logic br_free,
                      input logic rf, input logic lsf);
    logic            exp_full_n, exp_ack, exp_disp, avail;
    int              tgt, st;
    ctl_word         exp_ctl;
    logic [N_RS-1:0] exp_rs;
    iq.ld_iq          = ld;
    iq.control_word_i = w;
    iq.flush          = fl;
    iq.rs_empty       = rse;
    iq.resbr_empty    = br_free;
    iq.rob_full       = rf;
    iq.ldst_q_full    = lsf;
    exp_full_n = (mq.size() < DEPTH);
    exp_ack    = ld && exp_full_n && !fl;
    exp_ctl    = (mq.size() > 0) ? mq[0] : '0;
    tgt        = target_of(exp_ctl.op);
    avail      = (tgt == 1) ? br_free : (tgt == 2) ? !lsf : (rse != '0);
    exp_disp   = (mq.size() > 0) && !rf && !fl && avail;
    st         = (exp_disp && tgt == 0) ? pick(rse) : -1;
    exp_rs     = (st >= 0) ? (N_RS'(1) << st) : '0;
    @(negedge clk);
    obs_ack    = iq.ack_o;
    obs_full_n = iq.issue_q_full_n;
    obs_count  = 64'(iq.count_o);
    obs_rob    = iq.rob_load;
    obs_rs     = iq.rs_load;
    obs_br     = iq.resbr_load;
    obs_ls     = iq.ldst_load;
    obs_ctl    = iq.control_o;
    check("ack_o", obs_ack, exp_ack);
    check("issue_q_full_n", obs_full_n, exp_full_n);
    check("count_o", obs_count, 64'(mq.size()));
    check("control_o", obs_ctl, exp_ctl);
    check("rob_load", obs_rob, exp_disp);
    check("rs_load", obs_rs, exp_rs);
    check("resbr_load", obs_br, exp_disp && tgt == 1);
    check("ldst_load", obs_ls, exp_disp && tgt == 2);
    @(posedge clk);
    if (fl) begin
      mq.delete();
    end else begin
      if (exp_disp) void'(mq.pop_front());
      if (exp_ack) mq.push_back(w);
      if (st >= 0) rr = (st + 1) % N_RS;
    end
    #1;
  endtask

  task automatic idle_inputs();
    iq.ld_iq          = 1'b0;
    iq.control_word_i = '0;
    iq.flush          = 1'b0;
    iq.rs_empty       = '0;
    iq.resbr_empty    = 1'b0;
    iq.rob_full       = 1'b1;
    iq.ldst_q_full    = 1'b1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ack"}, iq.ack_o, 1'b0);
    check({tag, "_full_n"}, iq.issue_q_full_n, 1'b1);
    check({tag, "_count"}, 64'(iq.count_o), 64'd0);
    check({tag, "_ctl"}, iq.control_o, '0);
    check({tag, "_rob"}, iq.rob_load, 1'b0);
    check({tag, "_rs"}, iq.rs_load, '0);
    check({tag, "_br"}, iq.resbr_load, 1'b0);
    check({tag, "_ls"}, iq.ldst_load, 1'b0);
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst_n = 1'b1;
    mq.delete();
    rr = 0;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    #3;
    check_reset_outputs("rst");
    release_reset();
  endtask

  // Enqueue without dispatching (ROB held full).
  task automatic enq_only(input ctl_word w);
    step(1'b1, w, 1'b0, '1, 1'b1, 1'b1, 1'b0);
  endtask

  task automatic drain_one();
    step(1'b0, '0, 1'b0, '1, 1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    ctl_word         wl[15];
    logic [N_RS-1:0] exp_arb;
    idle_inputs();
    #1;
    do_reset();

    // Fill: eight ALU entries, then a ninth request is refused.
    for (int i = 0; i < DEPTH; i++) begin
      enq_only(mk(ADD));
      check("fill_ack", obs_ack, 1'b1);
    end
    step(1'b1, mk(SUB), 1'b0, '1, 1'b1, 1'b1, 1'b0);
    check("full_ack", obs_ack, 1'b0);
    check("full_count", obs_count, 64'(DEPTH));
    check("full_flag", obs_full_n, 1'b0);

    // Flush of a full queue with a simultaneous enqueue request.
    step(1'b1, mk(ADD), 1'b1, '1, 1'b1, 1'b0, 1'b0);
    check("flush_ack", obs_ack, 1'b0);
    check("flush_rob", obs_rob, 1'b0);
    drain_one();
    check("post_flush_count", obs_count, 64'd0);

    // Routing: BRANCH, LD, ADD dispatched on consecutive cycles.
    do_reset();
    enq_only(mk(BRANCH));
    enq_only(mk(LD));
    enq_only(mk(ADD));
    drain_one();
    check("route_br", obs_br, 1'b1);
    check("route_rob0", obs_rob, 1'b1);
    drain_one();
    check("route_ls", obs_ls, 1'b1);
    check("route_rob1", obs_rob, 1'b1);
    drain_one();
    check("route_rs", obs_rs, 4'b0001);
    check("route_rob2", obs_rob, 1'b1);

    // Blocking: LD at head waits while the load/store queue is full.
    enq_only(mk(LD));
    enq_only(mk(ADD));
    for (int i = 0; i < 3; i++) begin
      step(1'b0, '0, 1'b0, 4'b1111, 1'b1, 1'b0, 1'b1);
      check("block_rob", obs_rob, 1'b0);
      check("block_rs", obs_rs, '0);
      check("block_count", obs_count, 64'd2);
    end
    drain_one();
    check("unblock_ls", obs_ls, 1'b1);
    drain_one();

    // Arbitration: four ALU dispatches with every station free.
    do_reset();
    for (int i = 0; i < 4; i++) enq_only(mk(ADD));
    for (int i = 0; i < 4; i++) begin
      step(1'b0, '0, 1'b0, 4'b1111, 1'b1, 1'b0, 1'b0);
`ifdef IQ_RR_ARB_EN
      exp_arb = N_RS'(1) << i;
`else
      exp_arb = 4'b0001;
`endif
      check("arb_rs", obs_rs, exp_arb);
    end

    // Flush from count 5 with ld_iq high.
    for (int i = 0; i < 5; i++) enq_only(mk_rand());
    step(1'b1, mk(ADD), 1'b1, '1, 1'b1, 1'b0, 1'b0);
    check("flush5_count", obs_count, 64'd5);
    check("flush5_ack", obs_ack, 1'b0);
    check("flush5_loads", {obs_rob, obs_br, obs_ls, obs_rs}, '0);
    drain_one();
    check("flush5_after", obs_count, 64'd0);

    // Wrap: twelve enqueue/dispatch pairs carry the pointers past DEPTH.
    for (int i = 0; i < 15; i++) wl[i] = mk(op_t'($urandom_range(0, 8)));
    for (int i = 0; i < 3; i++) enq_only(wl[i]);
    for (int i = 0; i < 12; i++) begin
      step(1'b1, wl[i + 3], 1'b0, '1, 1'b1, 1'b0, 1'b0);
      check("wrap_order", obs_ctl, wl[i]);
      check("wrap_ack", obs_ack, 1'b1);
    end
    for (int i = 0; i < 3; i++) begin
      drain_one();
      check("wrap_drain", obs_ctl, wl[12 + i]);
    end

    // Randomized traffic: enqueue-heavy, then dispatch-heavy.
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 9) < ((i < 200) ? 8 : 3)), mk_rand(),
           ($urandom_range(0, 39) == 0), N_RS'($urandom),
           1'($urandom), ($urandom_range(0, 4) == 0), ($urandom_range(0, 3) == 0));
    end

    // Asynchronous reset while a dispatch and an enqueue request are in progress.
    for (int i = 0; i < 3; i++) enq_only(mk(ADD));
    iq.ld_iq          = 1'b1;
    iq.control_word_i = mk(SUB);
    iq.flush          = 1'b0;
    iq.rs_empty       = '1;
    iq.resbr_empty    = 1'b1;
    iq.rob_full       = 1'b0;
    iq.ldst_q_full    = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    idle_inputs();
    release_reset();
    drain_one();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
